// File: rtl/reu_pkg.sv
// Shared types and constants for the REU-to-SDRAM bridge.
package reu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        DELIVER  = 2'd3
    } reu_state_e;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        we;
    } reu_req_t;

    localparam int          EXT_LEN_DEF   = 4;
    localparam int          TO_CYCLES_DEF = 255;
    localparam logic [7:0]  RDATA_IDLE    = 8'hFF;

endpackage

// File: rtl/reu_req_slot.sv
// One-deep holding register for a REU access that arrives while the bridge is busy.
module reu_req_slot
    import reu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load_i,
    input  logic     pop_i,
    input  reu_req_t req_i,
    output reu_req_t req_o,
    output logic     valid_o
);

    reu_req_t req_q;
    logic     valid_q;

    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load_i) begin
                req_q   <= req_i;
                valid_q <= 1'b1;
            end else if (pop_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign req_o   = req_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/reu_sdram_bridge.sv
// Converts REU RAM strobes into a level SDRAM request and paces completion with ext_cyc.
// Optional ack timeout enabled by defining REU_BRIDGE_TIMEOUT_EN.
module reu_sdram_bridge
    import reu_pkg::*;
#(
    parameter int EXT_LEN   = EXT_LEN_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] req_addr,
    input  logic [7:0]  req_dout,
    input  logic        req_ce,
    input  logic        req_we,
    output logic [7:0]  req_din,
    output logic        ext_cyc,
    output logic [24:0] sd_addr,
    output logic [7:0]  sd_dout,
    output logic        sd_we,
    output logic        sd_req,
    input  logic        sd_ack,
    input  logic [7:0]  sd_din,
    output logic        err
);

    localparam logic [3:0] EXT_LAST = 4'(EXT_LEN - 1);
    localparam logic [7:0] TO_LAST  = 8'(TO_CYCLES - 1);

    reu_state_e  state_q, state_d;
    logic        req_ce_q;
    logic [3:0]  ext_cnt_q, ext_cnt_d;
    logic [24:0] sd_addr_q, sd_addr_d;
    logic [7:0]  sd_dout_q, sd_dout_d;
    logic        sd_we_q, sd_we_d;
    logic        sd_req_q, sd_req_d;
    logic [7:0]  req_din_q, req_din_d;

    logic        rise;
    logic        take;
    logic        pop;
    logic        load;
    logic        slot_valid;
    reu_req_t    slot_req;
    reu_req_t    new_req;

`ifdef REU_BRIDGE_TIMEOUT_EN
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        err_q, err_d;
`else
    logic        unused_to;
    assign unused_to = ^TO_LAST;
`endif

    assign rise    = req_ce & ~req_ce_q;
    assign new_req = '{addr: req_addr, dout: req_dout, we: req_we};

    reu_req_slot u_slot (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .pop_i   (pop),
        .req_i   (new_req),
        .req_o   (slot_req),
        .valid_o (slot_valid)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        ext_cnt_d = ext_cnt_q;
        sd_addr_d = sd_addr_q;
        sd_dout_d = sd_dout_q;
        sd_we_d   = sd_we_q;
        sd_req_d  = sd_req_q;
        req_din_d = req_din_q;
        take      = 1'b0;
        pop       = 1'b0;
`ifdef REU_BRIDGE_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (rise) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sd_req_d = 1'b1;
                state_d  = WAIT_ACK;
`ifdef REU_BRIDGE_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            WAIT_ACK: begin
                if (sd_ack) begin
                    sd_req_d  = 1'b0;
                    ext_cnt_d = '0;
                    state_d   = DELIVER;
                    if (!sd_we_q) req_din_d = sd_din;
`ifdef REU_BRIDGE_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    sd_req_d  = 1'b0;
                    ext_cnt_d = '0;
                    err_d     = 1'b1;
                    state_d   = DELIVER;
                    if (!sd_we_q) req_din_d = RDATA_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
`endif
                end
            end
            DELIVER: begin
                if (ext_cnt_q == EXT_LAST) begin
                    // A parked request goes first; a fresh edge then refills the slot.
                    if (slot_valid) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else if (rise) begin
                        take    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ext_cnt_d = ext_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            sd_addr_d = new_req.addr;
            sd_dout_d = new_req.dout;
            sd_we_d   = new_req.we;
        end else if (pop) begin
            sd_addr_d = slot_req.addr;
            sd_dout_d = slot_req.dout;
            sd_we_d   = slot_req.we;
        end
    end

    // An edge that cannot start an access is parked unless the slot stays full.
    assign load = rise & ~take & (~slot_valid | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_ce_q  <= 1'b0;
            ext_cnt_q <= '0;
            sd_addr_q <= '0;
            sd_dout_q <= '0;
            sd_we_q   <= 1'b0;
            sd_req_q  <= 1'b0;
            req_din_q <= RDATA_IDLE;
`ifdef REU_BRIDGE_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_ce_q  <= req_ce;
            ext_cnt_q <= ext_cnt_d;
            sd_addr_q <= sd_addr_d;
            sd_dout_q <= sd_dout_d;
            sd_we_q   <= sd_we_d;
            sd_req_q  <= sd_req_d;
            req_din_q <= req_din_d;
`ifdef REU_BRIDGE_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign ext_cyc = (state_q == DELIVER);
    assign sd_addr = sd_addr_q;
    assign sd_dout = sd_dout_q;
    assign sd_we   = sd_we_q;
    assign sd_req  = sd_req_q;
    assign req_din = req_din_q;
`ifdef REU_BRIDGE_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: doc/reu_sdram_bridge.md
REU_SDRAM_BRIDGE -- requirements
Module: reu_sdram_bridge

Interface
REQ-001 SHALL have parameter EXT_LEN, default 4, giving the cycles ext_cyc is held high per completed access (range 2..15).
REQ-002 SHALL have parameter TO_CYCLES, default 255, giving the ack-timeout limit in clk cycles (used only with REU_BRIDGE_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port req_addr, input, 25, REU RAM byte address.
REQ-006 SHALL have port req_dout, input, 8, REU write data.
REQ-007 SHALL have port req_ce, input, 1, REU access strobe, level; the access is taken on its rising edge.
REQ-008 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port req_din, output, 8, read data returned to the REU.
REQ-010 SHALL have port ext_cyc, output, 1, REU RAM slot indicator; drives the REU dma_ext_cyc.
REQ-011 SHALL have ports sd_addr (output, 25), sd_dout (output, 8) and sd_we (output, 1): the SDRAM request payload.
REQ-012 SHALL have port sd_req, output, 1, SDRAM request, level.
REQ-013 SHALL have ports sd_ack (input, 1, one-cycle completion pulse) and sd_din (input, 8, read data valid with sd_ack).
REQ-014 SHALL have port err, output, 1, sticky timeout flag (tied 0 without the macro).

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_ACK and DELIVER.
REQ-016 SHALL detect a rising edge of req_ce using a registered copy of req_ce; in IDLE this latches addr, dout and we and moves to ISSUE on the next cycle.
REQ-017 ISSUE SHALL drive sd_addr, sd_dout and sd_we from the latched values, set sd_req=1, and go to WAIT_ACK after one cycle.
REQ-018 WAIT_ACK SHALL hold sd_req=1 and the payload stable until sd_ack=1; on ack it SHALL clear sd_req in the same edge, capture sd_din into req_din when the access is a read, and enter DELIVER.
REQ-019 On write accesses, req_din SHALL keep its previous value.
REQ-020 DELIVER SHALL assert ext_cyc for exactly EXT_LEN consecutive cycles, then return to IDLE with ext_cyc=0.
REQ-021 ext_cyc SHALL be 0 in all states other than DELIVER.
REQ-022 Read data SHALL already be valid on req_din in the first ext_cyc cycle.
REQ-023 Minimum latency from the req_ce rise to the first ext_cyc cycle SHALL be 3 cycles plus the SDRAM ack delay.
REQ-024 A req_ce rising edge outside IDLE SHALL be stored in a 1-deep pending register (addr/dout/we); it SHALL be issued directly from DELIVER-exit to ISSUE.
REQ-025 A further edge while the pending register is full SHALL be dropped.
REQ-026 An sd_ack outside WAIT_ACK SHALL be ignored.
REQ-027 Addresses SHALL pass through unmodified; no wrap or masking is applied in this block.

Reset
REQ-028 On reset: state=IDLE, sd_req=0, sd_we=0, sd_addr=0, sd_dout=0, req_din=8'hFF, ext_cyc=0, err=0, pending cleared, registered req_ce cleared.
REQ-029 Reset during WAIT_ACK SHALL drop sd_req immediately; a late sd_ack SHALL then be ignored per REQ-026.

Configuration
REQ-030 Macro REU_BRIDGE_TIMEOUT_EN SHALL control the ack timeout.
REQ-031 With REU_BRIDGE_TIMEOUT_EN defined: an 8-bit counter runs in WAIT_ACK; after TO_CYCLES cycles without sd_ack the block SHALL drop sd_req, set req_din=8'hFF for reads, set err=1 (cleared only by reset), and enter DELIVER normally.
REQ-032 Without REU_BRIDGE_TIMEOUT_EN: no counter exists, WAIT_ACK waits indefinitely, and err is constant 0.

Structure
REQ-033 A shared package reu_pkg SHALL hold the state enum and the constants EXT_LEN_DEF=4, TO_CYCLES_DEF=255 and RDATA_IDLE=8'hFF.
REQ-034 A single sub-module, reu_req_slot, SHALL implement the pending request register (load, valid, pop); the state machine stays in the top module.

Verification
REQ-035 Read: req_addr=25'h1000010, req_we=0, req_ce rise; sd_ack after 5 cycles with sd_din=8'hA5 -> sd_req high 6 cycles, then ext_cyc high 4 cycles with req_din=8'hA5.
REQ-036 Write: req_dout=8'h3C, req_we=1 -> sd_we=1, sd_dout=8'h3C, req_din unchanged, ext_cyc pulse 4 cycles.
REQ-037 Back-to-back: second req_ce edge during WAIT_ACK -> issued right after the first DELIVER; a third edge while pending is full is dropped (exactly 2 sd_req pulses).
REQ-038 Reset asserted in WAIT_ACK, then sd_ack 2 cycles later -> sd_req=0, no ext_cyc, req_din=8'hFF.
REQ-039 With REU_BRIDGE_TIMEOUT_EN and sd_ack never asserted -> after 255 cycles err=1, req_din=8'hFF, ext_cyc pulse of 4 cycles.
REQ-040 Parameter EXT_LEN=2 -> ext_cyc is high exactly 2 cycles per access.
